// File: rtl/project_irq_pkg.sv
// Shared constants and helpers for the interrupt aggregator: register map,
// ACTIVE register layout and the lowest-index priority encoder.
package project_irq_pkg;

  localparam int IRQ_MAX_LINES        = 15;
  localparam int IRQ_ACTIVE_VALID_BIT = 15;

  localparam logic [2:0] IRQ_ADDR_STATUS = 3'd0;
  localparam logic [2:0] IRQ_ADDR_MASK   = 3'd1;
  localparam logic [2:0] IRQ_ADDR_EDGE   = 3'd2;
  localparam logic [2:0] IRQ_ADDR_ACTIVE = 3'd3;
  localparam logic [2:0] IRQ_ADDR_RAW    = 3'd4;

  // Lowest set index wins; scanning downward lets the last hit be the lowest.
  function automatic logic [3:0] irq_lowest_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/project_irq_line_sync.sv
// Per-line two-flop synchroniser with a history flop for rising-edge detect.
module project_irq_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // NOTE: reset is synchronous here, so it sits inside the clocked branch
  // and is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so each flop samples the previous stage's old value.
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign level = sync2_q;
  assign rise  = sync2_q & ~prev_q;

endmodule

// File: rtl/project_irq_controller.sv
// Memory-mapped interrupt aggregator: synchronise, latch, mask and encode
// up to 15 request lines into one registered CPU request.
module project_irq_controller
  import project_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out
);

  logic [NUM_IRQ-1:0] level;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] edge_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] pending_d;
  logic [NUM_IRQ-1:0] status_clr;
  logic [NUM_IRQ-1:0] enabled;
  logic [NUM_IRQ-1:0] wdata;
  logic               bus_wr;
  logic               wr_status;
  logic               wr_mask;
  logic               wr_edge;
  logic               any_active;
  logic [15:0]        active;
  logic [15:0]        read_mux;
  logic               unused_wdata;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    project_irq_line_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (irq_in[i]),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  // Bits above NUM_IRQ are write-ignored.
  assign wdata        = writedata[NUM_IRQ-1:0];
  assign unused_wdata = ^writedata;

  assign bus_wr    = chipselect && !write_n;
  assign wr_status = bus_wr && (address == IRQ_ADDR_STATUS);
  assign wr_mask   = bus_wr && (address == IRQ_ADDR_MASK);
  assign wr_edge   = bus_wr && (address == IRQ_ADDR_EDGE);

  // Edge lines: a new rise beats a same-cycle clear. Level lines track sync2.
  assign status_clr = wr_status ? wdata : '0;
  assign pending_d  = (edge_q & (rise | (pending_q & ~status_clr)))
                    | (~edge_q & level);

  assign enabled    = pending_q & mask_q;
  assign any_active = |enabled;

  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    active   = '0;
    read_mux = '0;
    if (any_active) begin
      active[IRQ_ACTIVE_VALID_BIT] = 1'b1;
      active[3:0]                  = irq_lowest_index(16'(enabled));
    end
    case (address)
      IRQ_ADDR_STATUS: read_mux = 16'(pending_q);
      IRQ_ADDR_MASK:   read_mux = 16'(mask_q);
      IRQ_ADDR_EDGE:   read_mux = 16'(edge_q);
      IRQ_ADDR_ACTIVE: read_mux = active;
      IRQ_ADDR_RAW:    read_mux = 16'(level);
      default:         read_mux = '0;
    endcase
  end

  // readdata updates every cycle so reads see pre-write register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q    <= '0;
      edge_q    <= '0;
      pending_q <= '0;
      irq_out   <= 1'b0;
      readdata  <= '0;
    end else begin
      if (wr_mask) mask_q <= wdata;
      if (wr_edge) edge_q <= wdata;
      pending_q <= pending_d;
      irq_out   <= any_active;
      readdata  <= read_mux;
    end
  end

endmodule

// File: tb/tb_project_irq_controller.sv
// Scoreboard bench: reads push expected values; a negedge monitor pops and
// compares readdata one cycle after each read strobe.
module tb_project_irq_controller;
  import project_irq_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata8;
  logic [15:0] readdata4;
  logic [7:0]  irq8;
  logic [3:0]  irq4;
  logic        irq_out8;
  logic        irq_out4;
  logic        rd_q;

  int checks = 0;
  int errors = 0;

  string       sb_name[$];
  logic [15:0] sb_exp[$];
  bit          sb_sel4[$];

  project_irq_controller #(.NUM_IRQ(8)) dut8 (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata8),
    .irq_in     (irq8),
    .irq_out    (irq_out8)
  );

  project_irq_controller #(.NUM_IRQ(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata4),
    .irq_in     (irq4),
    .irq_out    (irq_out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rd_q <= chipselect && write_n;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    string       n;
    logic [15:0] e;
    bit          s;
    if (rd_q) begin
      if (sb_name.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got a read response expected none");
      end else begin
        n = sb_name.pop_front();
        e = sb_exp.pop_front();
        s = sb_sel4.pop_front();
        check(n, s ? readdata4 : readdata8, e);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    idle(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input bit sel4, input string name);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    sb_name.push_back(name);
    sb_exp.push_back(exp);
    sb_sel4.push_back(sel4);
    idle(1);
    chipselect = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    irq8       = '0;
    irq4       = '0;
    idle(2);
    check("reset_readdata", readdata8, 16'h0000);
    check("reset_irq_out", 16'(irq_out8), 16'h0000);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, 1'b0, $sformatf("rd_reset_a%0d", a));

    // Single-cycle edge pulse on line 0: irq_out on the 4th edge.
    wr(IRQ_ADDR_MASK, 16'h0001);
    wr(IRQ_ADDR_EDGE, 16'h0001);
    irq8[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle(1);
      if (k == 0) irq8[0] = 1'b0;
      check($sformatf("edge_latency_k%0d", k), 16'(irq_out8), (k == 3) ? 16'h1 : 16'h0);
    end
    rd(IRQ_ADDR_STATUS, 16'h0001, 1'b0, "edge_status");
    rd(IRQ_ADDR_ACTIVE, 16'h8000, 1'b0, "edge_active");
    wr(IRQ_ADDR_STATUS, 16'h0001);
    check("irq_hold_at_clr", 16'(irq_out8), 16'h1);
    idle(1);
    check("irq_drop_after_clr", 16'(irq_out8), 16'h0);
    rd(IRQ_ADDR_STATUS, 16'h0000, 1'b0, "status_cleared");

    // Clear strobe sampled on the same edge as a new rise: set wins.
    irq8[0] = 1'b1;
    idle(2);
    wr(IRQ_ADDR_STATUS, 16'h0001);
    rd(IRQ_ADDR_STATUS, 16'h0001, 1'b0, "set_beats_clear");
    wr(IRQ_ADDR_STATUS, 16'h0001);
    rd(IRQ_ADDR_STATUS, 16'h0000, 1'b0, "held_line_no_reedge");
    irq8[0] = 1'b0;

    // Level mode on line 3.
    wr(IRQ_ADDR_MASK, 16'h0008);
    irq8[3] = 1'b1;
    idle(4);
    rd(IRQ_ADDR_ACTIVE, 16'h8003, 1'b0, "level_active");
    wr(IRQ_ADDR_STATUS, 16'h0008);
    rd(IRQ_ADDR_STATUS, 16'h0008, 1'b0, "level_ignores_clr");
    check("level_irq_out", 16'(irq_out8), 16'h1);
    irq8[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idle(1);
      check($sformatf("level_fall_k%0d", k), 16'(irq_out8), (k < 3) ? 16'h1 : 16'h0);
    end

    // Lines 2 and 5 in edge mode; line 2 latches while masked.
    wr(IRQ_ADDR_EDGE, 16'h0024);
    wr(IRQ_ADDR_MASK, 16'h0020);
    irq8[2] = 1'b1;
    irq8[5] = 1'b1;
    idle(1);
    irq8[2] = 1'b0;
    irq8[5] = 1'b0;
    idle(4);
    rd(IRQ_ADDR_STATUS, 16'h0024, 1'b0, "two_pending_status");
    rd(IRQ_ADDR_ACTIVE, 16'h8005, 1'b0, "prio_masked_low");
    wr(IRQ_ADDR_MASK, 16'h0024);
    rd(IRQ_ADDR_ACTIVE, 16'h8002, 1'b0, "prio_lowest");
    wr(IRQ_ADDR_STATUS, 16'h0024);
    rd(IRQ_ADDR_ACTIVE, 16'h0000, 1'b0, "active_empty");
    check("irq_out_after_w1c", 16'(irq_out8), 16'h0);

    // RAW view and a masked level line.
    irq8[6] = 1'b1;
    idle(3);
    rd(IRQ_ADDR_RAW, 16'h0040, 1'b0, "raw_sync2");
    rd(3'd5, 16'h0000, 1'b0, "unmapped_a5");
    rd(IRQ_ADDR_STATUS, 16'h0040, 1'b0, "masked_pending_latches");
    check("masked_no_irq", 16'(irq_out8), 16'h0);
    irq8[6] = 1'b0;
    idle(3);

    // NUM_IRQ=4 width clipping and reset mid-pending.
    wr(IRQ_ADDR_MASK, 16'hFFFF);
    rd(IRQ_ADDR_MASK, 16'h000F, 1'b1, "mask_clip4");
    rd(IRQ_ADDR_MASK, 16'h00FF, 1'b0, "mask_clip8");
    wr(IRQ_ADDR_EDGE, 16'h0001);
    irq4[0] = 1'b1;
    idle(1);
    irq4[0] = 1'b0;
    idle(4);
    rd(IRQ_ADDR_STATUS, 16'h0001, 1'b1, "n4_pending");
    check("n4_irq_out", 16'(irq_out4), 16'h1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("n4_reset_irq_out", 16'(irq_out4), 16'h0);
    check("n4_reset_readdata", readdata4, 16'h0000);
    check("n8_reset_irq_out", 16'(irq_out8), 16'h0);
    rd(IRQ_ADDR_STATUS, 16'h0000, 1'b1, "n4_reset_status");
    rd(IRQ_ADDR_MASK, 16'h0000, 1'b1, "n4_reset_mask");
    rd(IRQ_ADDR_EDGE, 16'h0000, 1'b1, "n4_reset_edge");

    idle(2);
    if (sb_name.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain: got %0d outstanding expected 0", sb_name.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
